// File: rtl/lcd_pkg.sv
// Shared constants and byte-formatting helpers for the HD44780-style LCD datapath.
package lcd_pkg;

    localparam logic [7:0] CMD_FUNCTION_SET  = 8'h38;
    localparam logic [7:0] CMD_DISPLAY_ON    = 8'h0C;
    localparam logic [7:0] CMD_ENTRY_MODE    = 8'h06;
    localparam logic [7:0] CMD_CLEAR         = 8'h01;

    localparam logic [7:0] CHAR_SPACE        = 8'h20;
    localparam logic [7:0] ADDR_CMD_BASE     = 8'h80;
    localparam logic [7:0] ADDR_LINE2_OFFSET = 8'h40;

    typedef enum logic [1:0] {
        INIT_FUNCTION_SET = 2'd0,
        INIT_DISPLAY_ON   = 2'd1,
        INIT_ENTRY_MODE   = 2'd2,
        INIT_CLEAR        = 2'd3
    } init_cmd_e;

    typedef enum logic [1:0] {
        SRC_INIT  = 2'd0,
        SRC_ADDR  = 2'd1,
        SRC_CHAR  = 2'd2,
        SRC_SPACE = 2'd3
    } mux_src_e;

    function automatic logic [7:0] init_cmd_byte(input init_cmd_e sel);
        logic [7:0] cmd;
        cmd = CMD_FUNCTION_SET;
        case (sel)
            INIT_FUNCTION_SET: cmd = CMD_FUNCTION_SET;
            INIT_DISPLAY_ON:   cmd = CMD_DISPLAY_ON;
            INIT_ENTRY_MODE:   cmd = CMD_ENTRY_MODE;
            INIT_CLEAR:        cmd = CMD_CLEAR;
            default:           cmd = CMD_FUNCTION_SET;
        endcase
        return cmd;
    endfunction

    // Set-DDRAM-address: bit 4 of the index selects the second display line.
    function automatic logic [7:0] addr_cmd_byte(input logic [4:0] idx);
        return ADDR_CMD_BASE | (idx[4] ? ADDR_LINE2_OFFSET : 8'h00) | {4'h0, idx[3:0]};
    endfunction

endpackage

// File: rtl/lcd_text_buffer.sv
// Two-line text buffer: one synchronous host write port, one combinational read by display index.
module lcd_text_buffer
    import lcd_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic       clk_1ms,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] mem_d [DEPTH];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        mem_d = mem_q;
        if (wr_en && (32'(wr_addr) < DEPTH)) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_1ms) begin
        if (reset) begin
            // NOTE: the array is reset explicitly so the panel shows blanks, which keeps it in flops, not a RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= CHAR_SPACE;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Reads see the pre-edge contents, so a same-cycle write is read-before-write.
    always_comb begin
        rd_data = CHAR_SPACE;
        if (32'(rd_addr) < DEPTH) begin
            rd_data = mem_q[rd_addr];
        end
    end

endmodule

// File: rtl/lcd_datapath.sv
// LCD data path: selects and registers the bus byte and tracks the cursor index on E falls.
module lcd_datapath
    import lcd_pkg::*;
#(
    parameter int LINE_LEN = 16
) (
    input  logic       clk_1ms,
    input  logic       reset,
    input  logic       data_sel,
    input  logic       DB_sel,
    input  logic [1:0] init_sel,
    input  logic [1:0] mux_sel,
    input  logic       E_in,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic [7:0] DB_out,
    output logic [4:0] char_idx,
    output logic       line_end
);

    localparam int         BUF_DEPTH   = 2 * LINE_LEN;
    localparam logic [4:0] IDX_LAST    = 5'(BUF_DEPTH - 1);
    localparam logic [4:0] LINE2_START = 5'(LINE_LEN);

    logic       e_q, e_d;
    logic [7:0] db_q, db_d;
    logic [4:0] idx_q, idx_d;
    logic       line_end_q, line_end_d;

    logic [7:0] buf_rd_data;
    logic [7:0] sel_byte;
    logic [4:0] idx_next;
    logic       fall;
    logic       is_clear;
    logic       is_char;

    lcd_text_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_text_buffer (
        .clk_1ms (clk_1ms),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (idx_q),
        .rd_data (buf_rd_data)
    );

    always_comb begin
        sel_byte = CHAR_SPACE;
        case (mux_src_e'(mux_sel))
            SRC_INIT:  sel_byte = init_cmd_byte(init_cmd_e'(init_sel));
            SRC_ADDR:  sel_byte = addr_cmd_byte(idx_q);
            SRC_CHAR:  sel_byte = buf_rd_data;
            SRC_SPACE: sel_byte = CHAR_SPACE;
            default:   sel_byte = CHAR_SPACE;
        endcase
    end

    always_comb begin
        e_d        = E_in;
        db_d       = DB_sel ? sel_byte : 8'h00;
        fall       = e_q & ~E_in;
        is_clear   = (mux_src_e'(mux_sel) == SRC_INIT) && (init_cmd_e'(init_sel) == INIT_CLEAR);
        is_char    = data_sel && (mux_src_e'(mux_sel) == SRC_CHAR);
        idx_next   = (idx_q == IDX_LAST) ? 5'd0 : idx_q + 5'd1;
        idx_d      = idx_q;
        line_end_d = 1'b0;

        // Clear/home outranks a character advance; a home never flags a line end.
        if (fall && is_clear) begin
            idx_d = 5'd0;
        end else if (fall && is_char) begin
            idx_d      = idx_next;
            line_end_d = (idx_next == LINE2_START) || (idx_next == 5'd0);
        end
    end

    always_ff @(posedge clk_1ms) begin
        if (reset) begin
            e_q        <= 1'b0;
            db_q       <= 8'h00;
            idx_q      <= 5'd0;
            line_end_q <= 1'b0;
        end else begin
            e_q        <= e_d;
            db_q       <= db_d;
            idx_q      <= idx_d;
            line_end_q <= line_end_d;
        end
    end

    assign DB_out   = db_q;
    assign char_idx = idx_q;
    assign line_end = line_end_q;

endmodule

// File: tb/tb_lcd_datapath.sv
// Self-checking bench for lcd_datapath: directed scenarios plus randomized traffic against a behavioural model.
module tb_lcd_datapath;

    logic       clk_1ms = 1'b0;
    logic       reset;
    logic       data_sel;
    logic       DB_sel;
    logic [1:0] init_sel;
    logic [1:0] mux_sel;
    logic       E_in;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] DB_out;
    logic [4:0] char_idx;
    logic       line_end;

    int total = 0;
    int bad   = 0;
    int le_count;

    // Behavioural model state
    logic [7:0] m_buf [32];
    int         m_idx;
    bit         m_e;
    logic [7:0] m_db;
    bit         m_le;

    always #5 clk_1ms = ~clk_1ms;

    lcd_datapath #(
        .LINE_LEN (16)
    ) dut (
        .clk_1ms  (clk_1ms),
        .reset    (reset),
        .data_sel (data_sel),
        .DB_sel   (DB_sel),
        .init_sel (init_sel),
        .mux_sel  (mux_sel),
        .E_in     (E_in),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .DB_out   (DB_out),
        .char_idx (char_idx),
        .line_end (line_end)
    );

    function automatic logic [7:0] init_byte(input int sel);
        logic [7:0] table_b [4];
        table_b = '{8'h38, 8'h0C, 8'h06, 8'h01};
        return table_b[sel];
    endfunction

    // Advance model and DUT by one clock with the inputs currently driven.
    task automatic tick();
        logic [7:0] sel;
        bit         fall;
        if (reset) begin
            for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
            m_idx = 0;
            m_e   = 0;
            m_db  = 8'h00;
            m_le  = 0;
        end else begin
            fall = m_e && !E_in;
            case (int'(mux_sel))
                0:       sel = init_byte(int'(init_sel));
                1:       sel = 8'h80 + ((m_idx >= 16) ? 8'h40 : 8'h00) + 8'(m_idx % 16);
                2:       sel = m_buf[m_idx];
                default: sel = 8'h20;
            endcase
            m_db = DB_sel ? sel : 8'h00;
            m_le = 0;
            if (fall && mux_sel == 2'd0 && init_sel == 2'd3) begin
                m_idx = 0;
            end else if (fall && data_sel && mux_sel == 2'd2) begin
                m_idx = (m_idx + 1) % 32;
                m_le  = (m_idx % 16 == 0);
            end
            if (wr_en) m_buf[wr_addr] = wr_data;
            m_e = E_in;
        end
        @(posedge clk_1ms);
        #1;
        if (line_end === 1'b1) le_count++;
    endtask

    task automatic idle_inputs();
        reset    = 1'b0;
        data_sel = 1'b0;
        DB_sel   = 1'b0;
        init_sel = 2'd0;
        mux_sel  = 2'd0;
        E_in     = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = 5'd0;
        wr_data  = 8'h00;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_e();
        E_in = 1'b1;
        tick();
        E_in = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        DB_sel   = 1'b1;
        mux_sel  = 2'd3;
        data_sel = 1'b1;
        E_in     = 1'b1;
        reset    = 1'b1;
        tick();
        total++; if (DB_out !== 8'h00) begin bad++; $display("FAIL reset_db: got %h expected 00", DB_out); end
        total++; if (char_idx !== 5'd0) begin bad++; $display("FAIL reset_idx: got %0d expected 0", char_idx); end
        total++; if (line_end !== 1'b0) begin bad++; $display("FAIL reset_le: got %b expected 0", line_end); end
        // E_in stays high across deassertion: no spurious fall
        reset   = 1'b0;
        mux_sel = 2'd2;
        tick();
        total++; if (char_idx !== 5'd0) begin bad++; $display("FAIL reset_no_spurious_fall: got %0d expected 0", char_idx); end
        total++; if (DB_out !== 8'h20) begin bad++; $display("FAIL reset_buf_blank: got %h expected 20", DB_out); end
        E_in = 1'b0;
        tick();
        total++; if (char_idx !== 5'd1) begin bad++; $display("FAIL reset_first_fall: got %0d expected 1", char_idx); end
    endtask

    task automatic test_init_cmds();
        logic [7:0] exp_cmd [4];
        exp_cmd = '{8'h38, 8'h0C, 8'h06, 8'h01};
        do_reset();
        DB_sel  = 1'b1;
        mux_sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            init_sel = 2'(i);
            total++; if (i > 0 && DB_out !== exp_cmd[i-1]) begin bad++; $display("FAIL init_latency_%0d: got %h expected %h", i, DB_out, exp_cmd[i-1]); end
            tick();
            total++; if (DB_out !== exp_cmd[i]) begin bad++; $display("FAIL init_cmd_%0d: got %h expected %h", i, DB_out, exp_cmd[i]); end
        end
        DB_sel = 1'b0;
        tick();
        total++; if (DB_out !== 8'h00) begin bad++; $display("FAIL db_sel_low: got %h expected 00", DB_out); end
    endtask

    task automatic test_hello();
        logic [7:0] hello [5];
        hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            wr_addr = 5'(i);
            wr_data = hello[i];
            tick();
        end
        wr_en    = 1'b0;
        data_sel = 1'b1;
        DB_sel   = 1'b1;
        mux_sel  = 2'd2;
        for (int i = 0; i < 5; i++) begin
            E_in = 1'b1;
            tick();
            total++; if (DB_out !== hello[i]) begin bad++; $display("FAIL hello_char_%0d: got %h expected %h", i, DB_out, hello[i]); end
            E_in = 1'b0;
            tick();
            total++; if (char_idx !== 5'(i + 1)) begin bad++; $display("FAIL hello_idx_%0d: got %0d expected %0d", i, char_idx, i + 1); end
        end
    endtask

    task automatic test_line_end();
        do_reset();
        data_sel = 1'b1;
        DB_sel   = 1'b1;
        mux_sel  = 2'd2;
        le_count = 0;
        for (int i = 0; i < 16; i++) pulse_e();
        total++; if (char_idx !== 5'd16) begin bad++; $display("FAIL line_idx: got %0d expected 16", char_idx); end
        total++; if (line_end !== 1'b1) begin bad++; $display("FAIL line_end_high: got %b expected 1", line_end); end
        tick();
        total++; if (line_end !== 1'b0) begin bad++; $display("FAIL line_end_one_cycle: got %b expected 0", line_end); end
        total++; if (le_count !== 1) begin bad++; $display("FAIL line_end_count: got %0d expected 1", le_count); end
        mux_sel = 2'd1;
        tick();
        total++; if (DB_out !== 8'hC0) begin bad++; $display("FAIL line2_addr_cmd: got %h expected c0", DB_out); end
    endtask

    task automatic test_wrap();
        do_reset();
        data_sel = 1'b1;
        DB_sel   = 1'b1;
        mux_sel  = 2'd2;
        le_count = 0;
        for (int i = 0; i < 31; i++) pulse_e();
        total++; if (char_idx !== 5'd31) begin bad++; $display("FAIL wrap_idx31: got %0d expected 31", char_idx); end
        pulse_e();
        total++; if (char_idx !== 5'd0) begin bad++; $display("FAIL wrap_idx: got %0d expected 0", char_idx); end
        total++; if (line_end !== 1'b1) begin bad++; $display("FAIL wrap_line_end: got %b expected 1", line_end); end
        total++; if (le_count !== 2) begin bad++; $display("FAIL wrap_le_count: got %0d expected 2", le_count); end
        mux_sel = 2'd1;
        tick();
        total++; if (DB_out !== 8'h80) begin bad++; $display("FAIL wrap_addr_cmd: got %h expected 80", DB_out); end
    endtask

    task automatic test_clear_and_reset();
        do_reset();
        data_sel = 1'b1;
        DB_sel   = 1'b1;
        mux_sel  = 2'd2;
        for (int i = 0; i < 7; i++) pulse_e();
        total++; if (char_idx !== 5'd7) begin bad++; $display("FAIL clear_pre_idx: got %0d expected 7", char_idx); end
        data_sel = 1'b0;
        mux_sel  = 2'd0;
        init_sel = 2'd3;
        le_count = 0;
        pulse_e();
        total++; if (char_idx !== 5'd0) begin bad++; $display("FAIL clear_idx: got %0d expected 0", char_idx); end
        total++; if (le_count !== 0) begin bad++; $display("FAIL clear_no_line_end: got %0d expected 0", le_count); end
        // A fall that is neither clear nor character holds the index
        mux_sel = 2'd2;
        for (int i = 0; i < 3; i++) pulse_e();
        mux_sel = 2'd3;
        data_sel = 1'b1;
        pulse_e();
        total++; if (char_idx !== 5'd0) begin bad++; $display("FAIL hold_no_data_sel: got %0d expected 0", char_idx); end
        mux_sel = 2'd2;
        for (int i = 0; i < 3; i++) pulse_e();
        mux_sel = 2'd3;
        pulse_e();
        total++; if (char_idx !== 5'd3) begin bad++; $display("FAIL hold_other_src: got %0d expected 3", char_idx); end
        mux_sel = 2'd2;
        E_in = 1'b1;
        tick();
        E_in  = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (char_idx !== 5'd0) begin bad++; $display("FAIL reset_vs_fall_idx: got %0d expected 0", char_idx); end
        total++; if (DB_out !== 8'h00) begin bad++; $display("FAIL reset_vs_fall_db: got %h expected 00", DB_out); end
    endtask

    task automatic test_read_before_write();
        do_reset();
        data_sel = 1'b1;
        DB_sel   = 1'b1;
        mux_sel  = 2'd2;
        for (int i = 0; i < 3; i++) pulse_e();
        total++; if (char_idx !== 5'd3) begin bad++; $display("FAIL rbw_idx: got %0d expected 3", char_idx); end
        wr_en   = 1'b1;
        wr_addr = 5'd3;
        wr_data = 8'h41;
        tick();
        wr_en = 1'b0;
        total++; if (DB_out !== 8'h20) begin bad++; $display("FAIL rbw_old: got %h expected 20", DB_out); end
        tick();
        total++; if (DB_out !== 8'h41) begin bad++; $display("FAIL rbw_new: got %h expected 41", DB_out); end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            reset    = ($urandom_range(0, 59) == 0);
            data_sel = ($urandom_range(0, 3) != 0);
            DB_sel   = ($urandom_range(0, 7) != 0);
            init_sel = 2'($urandom_range(0, 3));
            mux_sel  = ($urandom_range(0, 1) == 0) ? 2'd2 : 2'($urandom_range(0, 3));
            E_in     = 1'($urandom_range(0, 1));
            wr_en    = ($urandom_range(0, 2) == 0);
            wr_addr  = 5'($urandom_range(0, 31));
            wr_data  = 8'($urandom_range(0, 255));
            tick();
            total++; if (DB_out !== m_db) begin bad++; $display("FAIL rand_db cyc %0d: got %h expected %h", cyc, DB_out, m_db); end
            total++; if (char_idx !== 5'(m_idx)) begin bad++; $display("FAIL rand_idx cyc %0d: got %0d expected %0d", cyc, char_idx, m_idx); end
            total++; if (line_end !== m_le) begin bad++; $display("FAIL rand_le cyc %0d: got %b expected %b", cyc, line_end, m_le); end
        end
    endtask

    initial begin
        le_count = 0;
        idle_inputs();
        test_reset();
        test_init_cmds();
        test_hello();
        test_line_end();
        test_wrap();
        test_clear_and_reset();
        test_read_before_write();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
